// File: rtl/fetch_pc_unit.sv
// PC select, instruction-fetch handshake and IF/ID register of the RV32I core.
// Define MISALIGN_TRAP_EN to add the sticky misaligned-target error output.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_valid,
`ifdef MISALIGN_TRAP_EN
  output logic            misaligned,
`endif
  output logic            flush
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            flush_q, flush_d;
  logic            req_q, req_d;
  logic            mis_q, mis_d;

  logic            redirect;
  logic            transfer;
  logic [XLEN-1:0] target;

  assign redirect = jump | taken;
  assign target   = jump ? jump_target : branch_target;
  assign transfer = req_q & imem_ready;

  // Next-state: redirect > stall > sequential fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    mis_d         = mis_q;
    if (redirect) begin
      state_d       = S_FETCH;
      fetch_valid_d = 1'b0;
      inst_d        = NOP;
      flush_d       = 1'b1;
`ifdef MISALIGN_TRAP_EN
      pc_d          = target;
      if (target[1:0] != 2'b00) mis_d = 1'b1;
`else
      pc_d          = {target[XLEN-1:2], 2'b00};
`endif
    end else if (stall) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_FETCH;
        S_FETCH: begin
          if (transfer) begin
            inst_d        = imem_rdata;
            inst_pc_d     = pc_q;
            fetch_valid_d = 1'b1;
            pc_d          = pc_q + XLEN'(4);
          end else begin
            fetch_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          // The held word was consumed in the release cycle; do not present it twice.
          state_d       = S_FETCH;
          fetch_valid_d = 1'b0;
        end
        default: state_d = S_BOOT;
      endcase
    end
    if (mis_d) fetch_valid_d = 1'b0;
    req_d = (state_d == S_FETCH) && !mis_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= XLEN'(RESET_PC);
      inst_q        <= NOP;
      inst_pc_q     <= '0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      req_q         <= 1'b0;
      mis_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      req_q         <= req_d;
      mis_q         <= mis_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned  = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; memory returns 0xA000_0000 | addr.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, taken, jump, stall, imem_ready;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, fetch_valid, flush;
  logic [31:0] imem_addr, pc, inst, inst_pc;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hA000_0000 | imem_addr;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .taken(taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .inst(inst), .inst_pc(inst_pc),
    .fetch_valid(fetch_valid),
`ifdef MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; taken = 1'b0; jump = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    branch_target = '0; jump_target = '0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);

    // Sequential fetch
    rst = 1'b0;
    step();
    chk("boot_req", 32'(imem_req), 32'h1);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_fv", 32'(fetch_valid), 32'h0);
    step();
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_inst0", inst, 32'hA000_0000);
    chk("seq_fv", 32'(fetch_valid), 32'h1);
    step();
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_ipc4", inst_pc, 32'h4);
    step();
    chk("seq_addrC", imem_addr, 32'hC);
    chk("seq_inst8", inst, 32'hA000_0008);
    step();
    chk("seq_addr10", imem_addr, 32'h10);
    chk("seq_ipcC", inst_pc, 32'hC);

    // Taken branch from 0x10
    taken = 1'b1; branch_target = 32'h100;
    step();
    taken = 1'b0;
    chk("br_pc", pc, 32'h100);
    chk("br_flush", 32'(flush), 32'h1);
    chk("br_fv", 32'(fetch_valid), 32'h0);
    chk("br_inst_nop", inst, 32'h13);
    step();
    chk("br_flush_off", 32'(flush), 32'h0);
    chk("br_inst", inst, 32'hA000_0100);
    chk("br_ipc", inst_pc, 32'h100);
    chk("br_pc_next", pc, 32'h104);

    // Jump beats taken
    jump = 1'b1; jump_target = 32'h200; taken = 1'b1; branch_target = 32'h300;
    step();
    jump = 1'b0; taken = 1'b0;
    chk("jmp_pc", pc, 32'h200);
    chk("jmp_flush", 32'(flush), 32'h1);
    step();
    chk("jmp_flush_once", 32'(flush), 32'h0);
    chk("jmp_pc_next", pc, 32'h204);

    // Stall three cycles at 0x20
    jump = 1'b1; jump_target = 32'h1C;
    step();
    jump = 1'b0;
    step();
    chk("st_pre_pc", pc, 32'h20);
    chk("st_pre_inst", inst, 32'hA000_001C);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_pc", pc, 32'h20);
      chk("st_inst", inst, 32'hA000_001C);
      chk("st_ipc", inst_pc, 32'h1C);
      chk("st_req", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    step();
    chk("st_rel_req", 32'(imem_req), 32'h1);
    chk("st_rel_pc", pc, 32'h20);
    chk("st_rel_fv", 32'(fetch_valid), 32'h0);
    step();
    chk("st_res_inst", inst, 32'hA000_0020);
    chk("st_res_ipc", inst_pc, 32'h20);
    chk("st_res_fv", 32'(fetch_valid), 32'h1);
    chk("st_res_pc", pc, 32'h24);

    // Memory not ready, then redirect during the wait
    imem_ready = 1'b0;
    step();
    chk("nr_addr1", imem_addr, 32'h24);
    chk("nr_fv1", 32'(fetch_valid), 32'h0);
    step();
    chk("nr_addr2", imem_addr, 32'h24);
    taken = 1'b1; branch_target = 32'h40;
    step();
    taken = 1'b0; imem_ready = 1'b1;
    chk("nr_br_addr", imem_addr, 32'h40);
    chk("nr_br_flush", 32'(flush), 32'h1);
    chk("nr_br_inst", inst, 32'h13);
    step();
    chk("nr_res_inst", inst, 32'hA000_0040);
    chk("nr_res_pc", pc, 32'h44);

    // PC wrap
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    chk("wr_pc", pc, 32'hFFFF_FFFC);
    step();
    chk("wr_pc0", pc, 32'h0);
    chk("wr_ipc", inst_pc, 32'hFFFF_FFFC);
    chk("wr_inst", inst, 32'hFFFF_FFFC);

    // Misaligned jump target
    jump = 1'b1; jump_target = 32'h102;
    step();
    jump = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk("mis_pc", pc, 32'h102);
    chk("mis_flag", 32'(misaligned), 32'h1);
    chk("mis_req", 32'(imem_req), 32'h0);
    step();
    chk("mis_sticky", 32'(misaligned), 32'h1);
    chk("mis_req2", 32'(imem_req), 32'h0);
    chk("mis_fv", 32'(fetch_valid), 32'h0);
`else
    chk("mis_pc", pc, 32'h100);
    chk("mis_req", 32'(imem_req), 32'h1);
    step();
    chk("mis_pc_next", pc, 32'h104);
    chk("mis_ipc", inst_pc, 32'h100);
    chk("mis_fv", 32'(fetch_valid), 32'h1);
`endif

    // Reset mid-operation discards a pending redirect
    rst = 1'b1; taken = 1'b1; branch_target = 32'h500;
    step();
    taken = 1'b0;
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_flush", 32'(flush), 32'h0);
    chk("mrst_req", 32'(imem_req), 32'h0);
    chk("mrst_fv", 32'(fetch_valid), 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("mrst_mis", 32'(misaligned), 32'h0);
`endif
    rst = 1'b0;
    step();
    chk("mrst_boot_req", 32'(imem_req), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
